axis_frame_fifo: RTL and testbench

Single-clock AXI4-Stream frame FIFO that receives frames, holds each one until its `tlast` beat arrives, and releases only complete, good frames to the output. A frame whose last beat carries `tuser`=1 (bad frame) is discarded. When `DROP_WHEN_FULL`=1, a frame that overflows the buffer is also discarded. It is the frame-consuming far end of the `tlast`/`tuser` stream carried by the stream FIFOs, and sits in front of packet processing logic that must only see whole, valid frames.

---
 rtl/axis_frame_fifo_if.sv | 13 +
 rtl/axis_frame_fifo.sv | 121 ++++++++++++
 tb/tb_axis_frame_fifo.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_fifo_if.sv
// AXI4-Stream beat bundle (tdata/tvalid/tready/tlast/tuser) shared by the frame FIFO ports.
interface axis_frame_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_fifo.sv
// Single-clock AXI4-Stream frame FIFO: buffers each frame until tlast and only releases
// complete frames whose last beat had tuser=0; bad or overflowing frames are rolled back.
module axis_frame_fifo #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int DROP_WHEN_FULL = 0
) (
  input  logic              clk,
  input  logic              rst,
  axis_frame_fifo_if.slave  input_axis,
  axis_frame_fifo_if.master output_axis,
  output logic              overflow,
  output logic              bad_frame,
  output logic              good_frame
);

  typedef enum logic {NORMAL, DROP} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_d;
  logic [ADDR_WIDTH:0] wr_ptr_cur, wr_ptr_cur_d;
  logic [ADDR_WIDTH:0] rd_ptr;

  logic [DATA_WIDTH:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic                  mem_we;
  logic                  good_d, bad_d, ovf_d;
  logic                  full_cur, empty, in_ready, in_fire, read;
  logic                  out_valid, out_last;
  logic [DATA_WIDTH-1:0] out_data;

  assign empty    = (rd_ptr == wr_ptr);
  assign full_cur = (wr_ptr_cur[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr_cur[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign in_ready = !rst && ((DROP_WHEN_FULL != 0) ? 1'b1 : !full_cur);
  assign in_fire  = input_axis.tvalid && in_ready;
  assign read     = (output_axis.tready || !out_valid) && !empty;

  assign input_axis.tready  = in_ready;
  assign output_axis.tdata  = out_data;
  assign output_axis.tvalid = out_valid;
  assign output_axis.tlast  = out_last;
  assign output_axis.tuser  = 1'b0;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr;
    wr_ptr_cur_d = wr_ptr_cur;
    mem_we       = 1'b0;
    good_d       = 1'b0;
    bad_d        = 1'b0;
    ovf_d        = 1'b0;
    case (state_q)
      NORMAL: begin
        if (in_fire) begin
          if (full_cur) begin
            // Only reachable with DROP_WHEN_FULL=1: roll back and discard the rest of the frame
            wr_ptr_cur_d = wr_ptr;
            ovf_d        = 1'b1;
            if (!input_axis.tlast) state_d = DROP;
          end else begin
            mem_we       = 1'b1;
            wr_ptr_cur_d = wr_ptr_cur + 1'b1;
            if (input_axis.tlast) begin
              if (input_axis.tuser) begin
                wr_ptr_cur_d = wr_ptr;
                bad_d        = 1'b1;
              end else begin
                wr_ptr_d = wr_ptr_cur + 1'b1;
                good_d   = 1'b1;
              end
            end
          end
        end
      end
      DROP: begin
        if (in_fire && input_axis.tlast) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NORMAL;
      wr_ptr     <= '0;
      wr_ptr_cur <= '0;
      good_frame <= 1'b0;
      bad_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr     <= wr_ptr_d;
      wr_ptr_cur <= wr_ptr_cur_d;
      good_frame <= good_d;
      bad_frame  <= bad_d;
      overflow   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= {input_axis.tlast, input_axis.tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (output_axis.tready || !out_valid) out_valid <= !empty;
      if (read) begin
        {out_last, out_data} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr               <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo: one back-pressuring and one dropping instance, 8-deep.
module tb_axis_frame_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sel;
  logic [7:0] tb_data;
  logic       tb_valid, tb_last, tb_user, tb_out_ready;

  axis_frame_fifo_if #(.DATA_WIDTH(8)) in0 ();
  axis_frame_fifo_if #(.DATA_WIDTH(8)) out0 ();
  axis_frame_fifo_if #(.DATA_WIDTH(8)) in1 ();
  axis_frame_fifo_if #(.DATA_WIDTH(8)) out1 ();
  logic ovf0, bad0, good0, ovf1, bad1, good1;

  assign in0.tdata   = tb_data;
  assign in0.tlast   = tb_last;
  assign in0.tuser   = tb_user;
  assign in0.tvalid  = tb_valid & ~sel;
  assign in1.tdata   = tb_data;
  assign in1.tlast   = tb_last;
  assign in1.tuser   = tb_user;
  assign in1.tvalid  = tb_valid & sel;
  assign out0.tready = tb_out_ready;
  assign out1.tready = tb_out_ready;

  axis_frame_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DROP_WHEN_FULL(0)) dut0 (
    .clk(clk), .rst(rst), .input_axis(in0), .output_axis(out0),
    .overflow(ovf0), .bad_frame(bad0), .good_frame(good0)
  );

  axis_frame_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .DROP_WHEN_FULL(1)) dut1 (
    .clk(clk), .rst(rst), .input_axis(in1), .output_axis(out1),
    .overflow(ovf1), .bad_frame(bad1), .good_frame(good1)
  );

  logic       m_in_ready, m_valid, m_ready, m_last, m_user, m_good, m_bad, m_ovf;
  logic [7:0] m_data;
  assign m_in_ready = sel ? in1.tready  : in0.tready;
  assign m_valid    = sel ? out1.tvalid : out0.tvalid;
  assign m_ready    = tb_out_ready;
  assign m_last     = sel ? out1.tlast  : out0.tlast;
  assign m_user     = sel ? out1.tuser  : out0.tuser;
  assign m_data     = sel ? out1.tdata  : out0.tdata;
  assign m_good     = sel ? good1 : good0;
  assign m_bad      = sel ? bad1  : bad0;
  assign m_ovf      = sel ? ovf1  : ovf0;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the DUT's active edge.
  logic [8:0]  oq[$];
  int unsigned good_cnt = 0, bad_cnt = 0, ovf_cnt = 0, hold_err = 0, user_err = 0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_beat = '0;

  always @(negedge clk) begin
    if (m_good) good_cnt++;
    if (m_bad)  bad_cnt++;
    if (m_ovf)  ovf_cnt++;
    if (m_valid && m_user) user_err++;
    if (prev_stall && m_valid && ({m_last, m_data} != prev_beat)) hold_err++;
    if (m_valid && m_ready) oq.push_back({m_last, m_data});
    prev_stall = m_valid && !m_ready;
    prev_beat  = {m_last, m_data};
  end

  task automatic send(input logic [7:0] d, input logic last, input logic user);
    int unsigned n;
    n = 0;
    tb_data  = d;
    tb_last  = last;
    tb_user  = user;
    tb_valid = 1'b1;
    @(negedge clk);
    while (!m_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
  endtask

  task automatic wait_q(input string tag, input int unsigned want);
    int unsigned n;
    n = 0;
    while (oq.size() < want && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(oq.size()), 32'(want));
  endtask

  task automatic check_q(input string tag, input int unsigned base, input logic [8:0] e[$]);
    logic [31:0] got;
    for (int i = 0; i < e.size(); i++) begin
      got = (base + i < oq.size()) ? 32'(oq[base + i]) : 32'hDEAD;
      check($sformatf("%s[%0d]", tag, i), got, 32'(e[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned base, g0, b0, o0;
    logic [8:0]  exp[$];
    logic [3:0]  pat;

    sel = 1'b0; tb_valid = 1'b0; tb_data = '0; tb_last = 1'b0; tb_user = 1'b0;
    tb_out_ready = 1'b0; rst = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready0", 32'(in0.tready), 32'd0);
    check("rst_in_ready1", 32'(in1.tready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid0", 32'(out0.tvalid), 32'd0);
    check("rst_valid1", 32'(out1.tvalid), 32'd0);
    check("rst_data0", 32'({out0.tlast, out0.tdata}), 32'd0);
    check("rst_pulses", 32'({ovf0, bad0, good0, ovf1, bad1, good1}), 32'd0);
    check("post_rst_ready0", 32'(in0.tready), 32'd1);
    check("post_rst_ready1", 32'(in1.tready), 32'd1);

    // Basic frame and latency
    tb_out_ready = 1'b1;
    base = oq.size(); g0 = good_cnt;
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    check("t1_good_pulse", 32'(good0), 32'd1);
    check("t1_valid_early", 32'(out0.tvalid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_lat", 32'(out0.tvalid), 32'd1);
    check("t1_first_data", 32'(out0.tdata), 32'h11);
    check("t1_good_once", 32'(good0), 32'd0);
    wait_q("t1_drain", base + 3);
    exp = '{9'h011, 9'h022, 9'h133};
    check_q("t1_beat", base, exp);
    check("t1_good_cnt", good_cnt - g0, 32'd1);

    // Bad frame discarded, good frame follows
    base = oq.size(); g0 = good_cnt; b0 = bad_cnt;
    send(8'hA0, 1'b0, 1'b0);
    send(8'hA1, 1'b1, 1'b1);
    check("t2_bad_pulse", 32'(bad0), 32'd1);
    send(8'hB0, 1'b1, 1'b0);
    wait_q("t2_drain", base + 1);
    repeat (4) @(posedge clk);
    #1;
    check("t2_count", 32'(oq.size() - base), 32'd1);
    exp = '{9'h1B0};
    check_q("t2_beat", base, exp);
    check("t2_bad_cnt", bad_cnt - b0, 32'd1);
    check("t2_good_cnt", good_cnt - g0, 32'd1);

    // Overflow drop on the dropping instance
    sel = 1'b1;
    tb_out_ready = 1'b0;
    base = oq.size(); o0 = ovf_cnt;
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h90 + i), (i == 9), 1'b0);
      if (i == 7) check("t3_ovf_beat8", 32'(ovf1), 32'd0);
      if (i == 8) check("t3_ovf_beat9", 32'(ovf1), 32'd1);
      if (i == 9) check("t3_ovf_beat10", 32'(ovf1), 32'd0);
    end
    check("t3_in_ready", 32'(in1.tready), 32'd1);
    check("t3_valid", 32'(out1.tvalid), 32'd0);
    check("t3_ovf_cnt", ovf_cnt - o0, 32'd1);
    send(8'hC0, 1'b0, 1'b0);
    send(8'hC1, 1'b0, 1'b0);
    send(8'hC2, 1'b1, 1'b0);
    tb_out_ready = 1'b1;
    wait_q("t3_drain", base + 3);
    exp = '{9'h0C0, 9'h0C1, 9'h1C2};
    check_q("t3_beat", base, exp);
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;

    // Back-pressure when full
    tb_out_ready = 1'b0;
    base = oq.size();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++) send(8'(8'h40 + 16 * f + i), (i == 3), 1'b0);
    check("t4_ready_before", 32'(in0.tready), 32'd1);
    send(8'h60, 1'b0, 1'b0);
    check("t4_ready_full", 32'(in0.tready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_ready_held", 32'(in0.tready), 32'd0);
    tb_out_ready = 1'b1;
    send(8'h61, 1'b0, 1'b0);
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
    wait_q("t4_drain", base + 12);
    exp = '{9'h040, 9'h041, 9'h042, 9'h143, 9'h050, 9'h051, 9'h052, 9'h153,
            9'h060, 9'h061, 9'h062, 9'h163};
    check_q("t4_beat", base, exp);

    // Output stalls during a frame
    tb_out_ready = 1'b0;
    base = oq.size();
    for (int i = 0; i < 5; i++) send(8'(8'hD0 + i), (i == 4), 1'b0);
    pat = 4'b1001;
    for (int i = 0; i < 40 && oq.size() < base + 5; i++) begin
      tb_out_ready = pat[3 - (i % 4)];
      @(posedge clk);
      #1;
    end
    tb_out_ready = 1'b1;
    wait_q("t5_drain", base + 5);
    exp = '{9'h0D0, 9'h0D1, 9'h0D2, 9'h0D3, 9'h1D4};
    check_q("t5_beat", base, exp);
    check("t5_hold", hold_err, 32'd0);

    // Reset with committed data and a partial frame buffered
    tb_out_ready = 1'b0;
    send(8'h71, 1'b0, 1'b0);
    send(8'h72, 1'b1, 1'b0);
    send(8'h81, 1'b0, 1'b0);
    send(8'h82, 1'b0, 1'b0);
    check("t6_valid_before", 32'(out0.tvalid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_valid_after_rst", 32'(out0.tvalid), 32'd0);
    base = oq.size();
    tb_out_ready = 1'b1;
    send(8'h5A, 1'b1, 1'b0);
    wait_q("t6_drain", base + 1);
    repeat (6) @(posedge clk);
    #1;
    check("t6_count", 32'(oq.size() - base), 32'd1);
    exp = '{9'h15A};
    check_q("t6_beat", base, exp);
    check("final_hold", hold_err, 32'd0);
    check("final_tuser", user_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
